// File: rtl/popcnt_accum_if.sv
// rtl/popcnt_accum_if.sv - beat input and frame-result output handshakes of popcnt_accum
interface popcnt_accum_if #(
  parameter int ACC_W = 16,
  parameter int LEN_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_cnt;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [LEN_W-1:0] out_beats;
  logic             out_sat;
  logic             out_err;

  modport slave (
    input  in_valid, in_cnt, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_beats, out_sat, out_err
  );

  modport master (
    output in_valid, in_cnt, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_beats, out_sat, out_err
  );
endinterface

// File: rtl/popcnt_accum.sv
// rtl/popcnt_accum.sv - frames popcount beats into saturating totals with range/overflow flags
module popcnt_accum #(
  parameter int ACC_W = 16,
  parameter int LEN_W = 8
) (
  input logic          clk,
  input logic          reset_n,
  popcnt_accum_if.slave bus
);
  typedef enum logic {IDLE, ACC} state_e;

  localparam logic [LEN_W-1:0] BEAT_ONE = LEN_W'(1);

  state_e           state_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0] beats_q, beats_d;
  logic             sat_q, sat_d;
  logic             err_q, err_d;
  logic             out_valid_q;
  logic [ACC_W-1:0] out_sum_q;
  logic [LEN_W-1:0] out_beats_q;
  logic             out_sat_q;
  logic             out_err_q;
  logic [ACC_W:0]   sum_wide;
  logic             first_beat;
  logic             beat_fire;
  logic             out_fire;

  assign bus.in_ready  = !out_valid_q || bus.out_ready;
  assign beat_fire     = bus.in_valid && bus.in_ready;
  assign out_fire      = out_valid_q && bus.out_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_beats = out_beats_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.out_err   = out_err_q;

  // The first beat of a frame starts from zero so stale flags never leak in.
  always_comb begin
    first_beat = (state_q == IDLE);
    sum_wide   = (first_beat ? '0 : {1'b0, acc_q}) + {{(ACC_W-3){1'b0}}, bus.in_cnt};
    acc_d      = sum_wide[ACC_W] ? '1 : sum_wide[ACC_W-1:0];
    sat_d      = (!first_beat && sat_q) || sum_wide[ACC_W];
    err_d      = (!first_beat && err_q) || (bus.in_cnt > 4'd13);
    beats_d    = BEAT_ONE;
    if (!first_beat) begin
      beats_d = (beats_q == '1) ? beats_q : beats_q + BEAT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      beats_q     <= '0;
      sat_q       <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_beats_q <= '0;
      out_sat_q   <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      if (out_fire) begin
        out_valid_q <= 1'b0;
      end
      if (beat_fire) begin
        if (bus.in_last) begin
          // A same-cycle transfer is overridden here, giving back-to-back results.
          out_valid_q <= 1'b1;
          out_sum_q   <= acc_d;
          out_beats_q <= beats_d;
          out_sat_q   <= sat_d;
          out_err_q   <= err_d;
          state_q     <= IDLE;
          acc_q       <= '0;
          beats_q     <= '0;
          sat_q       <= 1'b0;
          err_q       <= 1'b0;
        end else begin
          state_q <= ACC;
          acc_q   <= acc_d;
          beats_q <= beats_d;
          sat_q   <= sat_d;
          err_q   <= err_d;
        end
      end
    end
  end
endmodule
